alu_iter: RTL
=============

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default `WORD_WIDTH, operand width; legal values are powers of two >= 4.
REQ-002 SHALL have parameter SHAMT_W, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-006 SHALL have port opcode  input  4  operation select, sampled at accept.
REQ-007 SHALL have ports in1, in2  input  WIDTH  operands, sampled at accept.
REQ-008 SHALL have port carry  input  1  carry/borrow-in, sampled at accept.
REQ-009 SHALL have port oe  input  1  output enable; gates out and out_hi combinationally to 0 when low, never gates flags.
REQ-010 SHALL have port busy  output  1  high while a multi-cycle operation runs.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a result becomes valid.
REQ-012 SHALL have port out  output  WIDTH  result low word (quotient for DIVU).
REQ-013 SHALL have port out_hi  output  WIDTH  product high word / remainder; 0 for all other ops.
REQ-014 SHALL have port flags  output  5  registered {P,S,Z,O,C}.

Function
REQ-015 Opcodes: 0 ADC, 1 SBB1 (in1-in2-carry), 2 SBB2 (in2-in1-carry), 3 NOR, 4 AND, 5 OR, 6 XOR, 7 SHL, 8 SHR, 9 SAR, 10 MUL (unsigned), 11 DIVU; 12-15 illegal.
REQ-016 States: IDLE, RUN, DONE; reset -> IDLE; IDLE/DONE + start -> RUN (shift amount>0, MUL, DIVU with in2!=0) else DONE; RUN -> DONE when iteration count expires; DONE without start -> IDLE.
REQ-017 busy SHALL equal (state==RUN); start while busy SHALL be ignored with no effect.
REQ-018 done SHALL be high exactly in DONE; out, out_hi, flags SHALL update on entry to DONE and hold until the next DONE entry.
REQ-019 Ops 0-6 and 12-15: done at T+1 (T = accept cycle); arithmetic, C and O rules as 9-bit-style carry-out/signed-overflow, logical ops C=O=0.
REQ-020 Shifts: shift in1 by in2[SHAMT_W-1:0] (upper in2 bits ignored), one bit per RUN cycle, done at T+1+n; n=0 gives out=in1, C=0, O=0, done at T+1.
REQ-021 Shift flags: C = last bit shifted out; SHL O = out[MSB]!=C; SHR O = original in1[MSB]; SAR O=0.
REQ-022 MUL: shift-add, WIDTH RUN cycles, done at T+WIDTH+1; {out_hi,out} = in1*in2; C=O=(out_hi!=0).
REQ-023 DIVU: restoring, WIDTH RUN cycles, done at T+WIDTH+1; out=quotient, out_hi=remainder, C=O=0.
REQ-024 DIVU with in2=0: no RUN, done at T+1, out all ones, out_hi=in1, O=1, C=0.
REQ-025 Illegal opcodes: out=0, out_hi=0, C=O=0.
REQ-026 For all ops Z=(out==0), S=out[MSB], P=~^out (out before oe gating).
REQ-027 Start accepted in DONE (back-to-back) SHALL follow the same timing as from IDLE.

Reset
REQ-028 reset high SHALL, at the next clk edge, force state IDLE, busy=0, done=0, out/out_hi registers=0, flags=0.
REQ-029 reset during RUN SHALL abort the operation with no done pulse; reset SHALL dominate a simultaneous start.

Structure
REQ-030 Opcode values and flag bit indices SHALL live in the shared header alu_defs.vh, also used by the existing single-cycle ALU.
REQ-031 Single-cycle ops SHALL be a sub-module alu_iter_comb; sequencer, shifter, multiplier and divider datapath stay in alu_iter.

Verification (WIDTH=16)
REQ-032 ADC 0xFFFF+0x0001, carry=0 -> out=0x0000, flags P=1,S=0,Z=1,O=0,C=1, done at T+1.
REQ-033 MUL 0x1234*0x0010 -> out=0x2340, out_hi=0x0001, C=O=1, busy T+1..T+16, done at T+17.
REQ-034 DIVU 100/7 -> out=14, out_hi=2, done at T+17; DIVU 0x1234/0 -> out=0xFFFF, out_hi=0x1234, O=1, done at T+1.
REQ-035 SAR 0x8004 by 2 -> out=0xE001, C=0, S=1, done at T+3; SHL 0x8001 by 3 -> out=0x0008, C=0, O=0.
REQ-036 start during MUL RUN ignored; reset asserted at T+5 of MUL -> no done, busy=0, out=0 next cycle.
REQ-037 oe=0 after any op -> out=out_hi=0, flags unchanged.

Source files
------------

// File: rtl/alu_iter_pkg.sv
// Shared ALU definitions: default word width, opcode encodings and flag bit
// positions, common to the iterative ALU and the single-cycle ALU.
package alu_iter_pkg;

   localparam int WORD_WIDTH = 16;

   localparam logic [3:0] OP_ADC  = 4'd0;
   localparam logic [3:0] OP_SBB1 = 4'd1;
   localparam logic [3:0] OP_SBB2 = 4'd2;
   localparam logic [3:0] OP_NOR  = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_XOR  = 4'd6;
   localparam logic [3:0] OP_SHL  = 4'd7;
   localparam logic [3:0] OP_SHR  = 4'd8;
   localparam logic [3:0] OP_SAR  = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;
   localparam logic [3:0] OP_DIVU = 4'd11;

   // flags vector is {P,S,Z,O,C}
   localparam int FLAG_C = 0;
   localparam int FLAG_O = 1;
   localparam int FLAG_Z = 2;
   localparam int FLAG_S = 3;
   localparam int FLAG_P = 4;

endpackage

// File: rtl/alu_iter_comb.sv
// Single-cycle ALU operations (add/subtract with carry, bitwise logic).
// Any opcode not handled here yields a zero result with C=O=0.
module alu_iter_comb
   import alu_iter_pkg::*;
#(
   parameter int WIDTH = WORD_WIDTH
) (
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             carry,
   output logic [WIDTH-1:0] res,
   output logic             c,
   output logic             o
);

   localparam int MSB = WIDTH - 1;

   logic [WIDTH:0] wide;

   // result, carry/borrow-out and signed overflow for the single-cycle ops
   always_comb begin
      res  = '0;
      c    = 1'b0;
      o    = 1'b0;
      wide = '0;
      case (opcode)
         OP_ADC: begin
            wide = {1'b0, in1} + {1'b0, in2} + {{WIDTH{1'b0}}, carry};
            res  = wide[WIDTH-1:0];
            c    = wide[WIDTH];
            o    = (in1[MSB] == in2[MSB]) && (res[MSB] != in1[MSB]);
         end
         OP_SBB1: begin
            wide = {1'b0, in1} - {1'b0, in2} - {{WIDTH{1'b0}}, carry};
            res  = wide[WIDTH-1:0];
            c    = wide[WIDTH];
            o    = (in1[MSB] != in2[MSB]) && (res[MSB] != in1[MSB]);
         end
         OP_SBB2: begin
            wide = {1'b0, in2} - {1'b0, in1} - {{WIDTH{1'b0}}, carry};
            res  = wide[WIDTH-1:0];
            c    = wide[WIDTH];
            o    = (in2[MSB] != in1[MSB]) && (res[MSB] != in2[MSB]);
         end
         OP_NOR:  res = ~(in1 | in2);
         OP_AND:  res = in1 & in2;
         OP_OR:   res = in1 | in2;
         OP_XOR:  res = in1 ^ in2;
         default: res = '0;
      endcase
   end

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle ops via alu_iter_comb, plus bit-serial shifts,
// shift-add multiply and restoring divide sequenced by a small FSM.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | multi-cycle op in progress, cnt counts remaining iterations
// DONE   | result valid for one cycle, new start accepted here too
module alu_iter
   import alu_iter_pkg::*;
#(
   parameter int WIDTH   = WORD_WIDTH,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             carry,
   input  logic             oe,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_hi,
   output logic [4:0]       flags
);

   localparam int CNT_W = SHAMT_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q, hi_q;
   logic             msb_q;
   logic [WIDTH-1:0] out_q, out_hi_q;
   logic [4:0]       flags_q;

   logic [SHAMT_W-1:0] shamt;
   logic               is_shift, run_req, last_step;
   logic [WIDTH-1:0]   comb_res;
   logic               comb_c, comb_o;
   logic [WIDTH-1:0]   imm_out, imm_hi;
   logic               imm_c, imm_o;
   logic [WIDTH-1:0]   step_a, step_hi;
   logic               step_c;
   logic [WIDTH:0]     mul_sum, div_rs;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   fin_out, fin_hi;
   logic               fin_c, fin_o;
   logic [4:0]         fin_flags;

   alu_iter_comb #(.WIDTH(WIDTH)) u_comb (
      .opcode (opcode),
      .in1    (in1),
      .in2    (in2),
      .carry  (carry),
      .res    (comb_res),
      .c      (comb_c),
      .o      (comb_o)
   );

   assign shamt     = in2[SHAMT_W-1:0];
   assign is_shift  = opcode inside {OP_SHL, OP_SHR, OP_SAR};
   assign run_req   = (is_shift && (shamt != '0)) || (opcode == OP_MUL) ||
                      ((opcode == OP_DIVU) && (in2 != '0));
   assign last_step = (state == S_RUN) && (cnt == CNT_ONE);

   // results for ops that finish directly from accept (no RUN phase)
   always_comb begin
      imm_out = comb_res;
      imm_hi  = '0;
      imm_c   = comb_c;
      imm_o   = comb_o;
      if (is_shift) begin
         imm_out = in1;
         imm_c   = 1'b0;
         imm_o   = 1'b0;
      end else if (opcode == OP_DIVU) begin
         imm_out = '1;
         imm_hi  = in1;
         imm_c   = 1'b0;
         imm_o   = 1'b1;
      end
   end

   // one iteration of the running shift / multiply / divide
   always_comb begin
      step_a   = a_q;
      step_hi  = hi_q;
      step_c   = 1'b0;
      mul_sum  = {1'b0, hi_q} + (a_q[0] ? {1'b0, b_q} : '0);
      div_rs   = {hi_q, a_q[WIDTH-1]};
      div_ge   = div_rs >= {1'b0, b_q};
      div_diff = div_rs[WIDTH-1:0] - b_q;
      case (op_q)
         OP_SHL: begin
            step_a = {a_q[WIDTH-2:0], 1'b0};
            step_c = a_q[WIDTH-1];
         end
         OP_SHR: begin
            step_a = {1'b0, a_q[WIDTH-1:1]};
            step_c = a_q[0];
         end
         OP_SAR: begin
            step_a = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
            step_c = a_q[0];
         end
         OP_MUL: begin
            step_hi = mul_sum[WIDTH:1];
            step_a  = {mul_sum[0], a_q[WIDTH-1:1]};
         end
         OP_DIVU: begin
            step_hi = div_ge ? div_diff : div_rs[WIDTH-1:0];
            step_a  = {a_q[WIDTH-2:0], div_ge};
         end
         default: step_a = a_q;
      endcase
   end

   // select the value to latch on DONE entry and derive P/S/Z from it
   always_comb begin
      if (state == S_RUN) begin
         fin_out = step_a;
         fin_hi  = '0;
         fin_c   = step_c;
         fin_o   = 1'b0;
         case (op_q)
            OP_SHL:  fin_o = step_a[WIDTH-1] ^ step_c;
            OP_SHR:  fin_o = msb_q;
            OP_MUL: begin
               fin_hi = step_hi;
               fin_c  = (step_hi != '0);
               fin_o  = (step_hi != '0);
            end
            OP_DIVU: begin
               fin_hi = step_hi;
               fin_c  = 1'b0;
            end
            default: fin_o = 1'b0;
         endcase
      end else begin
         fin_out = imm_out;
         fin_hi  = imm_hi;
         fin_c   = imm_c;
         fin_o   = imm_o;
      end
      fin_flags         = '0;
      fin_flags[FLAG_P] = ~^fin_out;
      fin_flags[FLAG_S] = fin_out[WIDTH-1];
      fin_flags[FLAG_Z] = (fin_out == '0);
      fin_flags[FLAG_O] = fin_o;
      fin_flags[FLAG_C] = fin_c;
   end

   // sequencer and datapath registers; start is only looked at outside RUN
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         hi_q     <= '0;
         msb_q    <= 1'b0;
         out_q    <= '0;
         out_hi_q <= '0;
         flags_q  <= '0;
      end else begin
         case (state)
            S_RUN: begin
               a_q  <= step_a;
               hi_q <= step_hi;
               cnt  <= cnt - CNT_ONE;
               if (last_step) begin
                  state    <= S_DONE;
                  out_q    <= fin_out;
                  out_hi_q <= fin_hi;
                  flags_q  <= fin_flags;
               end
            end
            default: begin
               if (start) begin
                  op_q <= opcode;
                  if (run_req) begin
                     state <= S_RUN;
                     cnt   <= is_shift ? CNT_W'(shamt) : CNT_FULL;
                     msb_q <= in1[WIDTH-1];
                     hi_q  <= '0;
                     if (opcode == OP_MUL) begin
                        a_q <= in2;
                        b_q <= in1;
                     end else begin
                        a_q <= in1;
                        b_q <= in2;
                     end
                  end else begin
                     state    <= S_DONE;
                     out_q    <= fin_out;
                     out_hi_q <= fin_hi;
                     flags_q  <= fin_flags;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign busy   = (state == S_RUN);
   assign done   = (state == S_DONE);
   assign out    = oe ? out_q : '0;
   assign out_hi = oe ? out_hi_q : '0;
   assign flags  = flags_q;

endmodule
